// File: rtl/sequence_multiplier.sv
`default_nettype none
// ============================================================================
// sequence_multiplier: folds a stream of 2x2 complex gate matrices into one
// running product using a single serialized complex multiply-accumulate.
// Revision: 1.0
// ============================================================================
module sequence_multiplier #(
    parameter int SEQ_INDEX_BITS = 5,
    parameter int NUMERIC_BITS   = 19,
    parameter int FRAC_BITS      = 17
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SEQ_INDEX_BITS-1:0] seq_index,
    input  logic [4:0]                seq_gate,
    input  logic                      ready,
    input  logic                      first,
    output logic                      available,
    output logic [4:0]                gate_addr,
    input  logic [8*NUMERIC_BITS-1:0] gate_data,
    output logic [8*NUMERIC_BITS-1:0] result_data,
    output logic                      result_valid
);

    localparam int N  = NUMERIC_BITS;
    localparam int PW = 2*N + 1;
    localparam int SW = 2*N + 2;
    localparam int HI = SW - FRAC_BITS - N;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_MAC     = 3'd3,
        ST_COMMIT  = 3'd4,
        ST_FINISH  = 3'd5
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [2:0]          step;
    logic                first_q;
    logic                last_q;
    logic                accept;

    logic signed [N-1:0] cache_re [4];
    logic signed [N-1:0] cache_im [4];
    logic signed [N-1:0] gate_re  [4];
    logic signed [N-1:0] gate_im  [4];
    logic signed [N-1:0] tmp_re   [4];
    logic signed [N-1:0] tmp_im   [4];
    logic [N-1:0]        data_re  [4];
    logic [N-1:0]        data_im  [4];
    logic signed [PW-1:0] acc_re;
    logic signed [PW-1:0] acc_im;

    // Entry e lives at component slots 2e (real) and 2e+1 (imaginary).
    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            assign data_re[i] = gate_data[(2*i)*N +: N];
            assign data_im[i] = gate_data[(2*i+1)*N +: N];
            assign result_data[(2*i)*N +: N]   = cache_re[i];
            assign result_data[(2*i+1)*N +: N] = cache_im[i];
        end
    endgenerate

    assign available = (state == ST_IDLE);
    assign accept    = ready && available;

    // ------------------------------------------------------------------
    // MAC datapath: step = {row, col, term}; term selects cache[r][t]*G[t][c]
    // ------------------------------------------------------------------
    logic [1:0]            entry;
    logic                  term;
    logic [1:0]            cache_sel;
    logic [1:0]            gate_sel;
    logic signed [2*N-1:0] ac, bd, ad, bc;
    logic signed [PW-1:0]  prod_re, prod_im;
    logic signed [SW-1:0]  sum_re, sum_im;
    logic [N-1:0]          res_re, res_im;
    logic [HI-1:0]         sum_hi_unused_re, sum_hi_unused_im;
    logic [FRAC_BITS-1:0]  sum_lo_unused_re, sum_lo_unused_im;

    function automatic logic signed [2*N-1:0] sext(input logic signed [N-1:0] v);
        return {{N{v[N-1]}}, v};
    endfunction

    assign entry     = step[2:1];
    assign term      = step[0];
    assign cache_sel = {entry[1], term};
    assign gate_sel  = {term, entry[0]};

    assign ac = sext(cache_re[cache_sel]) * sext(gate_re[gate_sel]);
    assign bd = sext(cache_im[cache_sel]) * sext(gate_im[gate_sel]);
    assign ad = sext(cache_re[cache_sel]) * sext(gate_im[gate_sel]);
    assign bc = sext(cache_im[cache_sel]) * sext(gate_re[gate_sel]);

    assign prod_re = {ac[2*N-1], ac} - {bd[2*N-1], bd};
    assign prod_im = {ad[2*N-1], ad} + {bc[2*N-1], bc};

    assign sum_re = {acc_re[PW-1], acc_re} + {prod_re[PW-1], prod_re};
    assign sum_im = {acc_im[PW-1], acc_im} + {prod_im[PW-1], prod_im};

    // Arithmetic shift then wrap: keep the N bits just above the fraction.
    assign {sum_hi_unused_re, res_re, sum_lo_unused_re} = sum_re;
    assign {sum_hi_unused_im, res_im, sum_lo_unused_im} = sum_im;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (ready) state_next = ST_FETCH;
            ST_FETCH:   state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = first_q ? ST_FINISH : ST_MAC;
            ST_MAC:     if (step == 3'd7) state_next = ST_COMMIT;
            ST_COMMIT:  state_next = ST_FINISH;
            ST_FINISH:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            step         <= 3'd0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            gate_addr    <= 5'd0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_next;
            result_valid <= (state_next == ST_FINISH) && last_q;
            if (accept) begin
                gate_addr <= seq_gate;
                first_q   <= first;
                last_q    <= (seq_index == '0);
            end
            if (state == ST_CAPTURE) begin
                step <= 3'd0;
            end else if (state == ST_MAC) begin
                step <= step + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Matrix storage and accumulation
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_re <= '0;
            acc_im <= '0;
            for (int i = 0; i < 4; i++) begin
                cache_re[i] <= '0;
                cache_im[i] <= '0;
                gate_re[i]  <= '0;
                gate_im[i]  <= '0;
                tmp_re[i]   <= '0;
                tmp_im[i]   <= '0;
            end
        end else begin
            case (state)
                ST_CAPTURE: begin
                    for (int i = 0; i < 4; i++) begin
                        gate_re[i] <= data_re[i];
                        gate_im[i] <= data_im[i];
                        if (first_q) begin
                            cache_re[i] <= data_re[i];
                            cache_im[i] <= data_im[i];
                        end
                    end
                end
                ST_MAC: begin
                    if (!term) begin
                        acc_re <= prod_re;
                        acc_im <= prod_im;
                    end else begin
                        tmp_re[entry] <= res_re;
                        tmp_im[entry] <= res_im;
                    end
                end
                ST_COMMIT: begin
                    for (int i = 0; i < 4; i++) begin
                        cache_re[i] <= tmp_re[i];
                        cache_im[i] <= tmp_im[i];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sequence_multiplier.sv
`default_nettype none
// tb_sequence_multiplier: directed and random gate sequences checked against a
// plain-arithmetic 2x2 complex matrix product model.
module tb_sequence_multiplier;

    localparam int     SIB = 5;
    localparam int     NB  = 19;
    localparam int     FB  = 17;
    localparam int     DW  = 8*NB;
    localparam longint ONE = 131072;

    logic           clk = 1'b0;
    logic           reset;
    logic [SIB-1:0] seq_index;
    logic [4:0]     seq_gate;
    logic           ready;
    logic           first;
    logic           available;
    logic [4:0]     gate_addr;
    logic [DW-1:0]  gate_data;
    logic [DW-1:0]  result_data;
    logic           result_valid;

    logic [DW-1:0]  rom [32];
    longint         mre [4];
    longint         mim [4];
    int             n_checks = 0;
    int             n_fail   = 0;

    sequence_multiplier #(
        .SEQ_INDEX_BITS(SIB),
        .NUMERIC_BITS  (NB),
        .FRAC_BITS     (FB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .seq_index   (seq_index),
        .seq_gate    (seq_gate),
        .ready       (ready),
        .first       (first),
        .available   (available),
        .gate_addr   (gate_addr),
        .gate_data   (gate_data),
        .result_data (result_data),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    // Synchronous gate ROM: data follows the registered address by one cycle.
    always @(posedge clk) gate_data <= rom[gate_addr];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint wrap(input longint v);
        logic signed [NB-1:0] s;
        s = v[NB-1:0];
        return longint'(s);
    endfunction

    function automatic longint comp(input logic [DW-1:0] w, input int idx);
        logic signed [NB-1:0] s;
        s = w[idx*NB +: NB];
        return longint'(s);
    endfunction

    function automatic logic [DW-1:0] mat8(input longint r0, input longint i0,
                                           input longint r1, input longint i1,
                                           input longint r2, input longint i2,
                                           input longint r3, input longint i3);
        return {i3[NB-1:0], r3[NB-1:0], i2[NB-1:0], r2[NB-1:0],
                i1[NB-1:0], r1[NB-1:0], i0[NB-1:0], r0[NB-1:0]};
    endfunction

    function automatic logic [DW-1:0] model_pack();
        return mat8(mre[0], mim[0], mre[1], mim[1], mre[2], mim[2], mre[3], mim[3]);
    endfunction

    task automatic model_clear();
        for (int e = 0; e < 4; e++) begin
            mre[e] = 0;
            mim[e] = 0;
        end
    endtask

    // new[r][c] = floor(sum_t cache[r][t] * G[t][c] / ONE), wrapped to NB bits
    task automatic model_apply(input int g, input bit f);
        longint gre [4];
        longint gim [4];
        longint nre [4];
        longint nim [4];
        longint sr, si;
        for (int e = 0; e < 4; e++) begin
            gre[e] = comp(rom[g], 2*e);
            gim[e] = comp(rom[g], 2*e+1);
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                sr = 0;
                si = 0;
                for (int t = 0; t < 2; t++) begin
                    sr += mre[2*r+t]*gre[2*t+c] - mim[2*r+t]*gim[2*t+c];
                    si += mre[2*r+t]*gim[2*t+c] + mim[2*r+t]*gre[2*t+c];
                end
                nre[2*r+c] = wrap(sr >>> FB);
                nim[2*r+c] = wrap(si >>> FB);
            end
        end
        for (int e = 0; e < 4; e++) begin
            mre[e] = f ? gre[e] : nre[e];
            mim[e] = f ? gim[e] : nim[e];
        end
    endtask

    // Offer one gate, follow it to completion and check timing and result.
    task automatic send(input string name, input int g, input int idx, input bit f, input bit hold);
        int lat, vpos, nv, addr_bad, exp_lat, exp_vpos;
        exp_lat  = f ? 3 : 12;
        exp_vpos = (idx == 0) ? exp_lat - 1 : -1;
        check({name, "_avail_pre"}, DW'(available), DW'(1'b1));
        seq_gate  = 5'(g);
        seq_index = SIB'(idx);
        first     = f;
        ready     = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) ready = 1'b0;
        lat = 0; vpos = -1; nv = 0; addr_bad = 0;
        while (!available && lat < 40) begin
            if (gate_addr !== 5'(g)) addr_bad++;
            if (result_valid) begin
                nv++;
                vpos = lat;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        ready = 1'b0;
        model_apply(g, f);
        check({name, "_latency"},   DW'(lat),      DW'(exp_lat));
        check({name, "_valid_cnt"}, DW'(nv),       DW'((idx == 0) ? 1 : 0));
        check({name, "_valid_pos"}, DW'(vpos),     DW'(exp_vpos));
        check({name, "_addr_hold"}, DW'(addr_bad), DW'(0));
        check({name, "_valid_end"}, DW'(result_valid), DW'(1'b0));
        check({name, "_result"},    result_data,   model_pack());
    endtask

    initial begin
        int len, g;
        bit f;
        reset = 1'b1; ready = 1'b0; seq_index = '0; seq_gate = '0; first = 1'b0;
        rom[0] = mat8(ONE, 0, 0, 0, 0, 0, ONE, 0);             // I
        rom[1] = mat8(0, 0, ONE, 0, ONE, 0, 0, 0);             // X
        rom[2] = mat8(92682, 0, 92682, 0, 92682, 0, -92682, 0); // H
        rom[3] = mat8(ONE, 0, 0, 0, 0, 0, -ONE, 0);            // Z
        rom[4] = mat8(ONE, 0, 0, 0, 0, 0, 0, ONE);             // S
        for (int i = 5; i < 32; i++) begin
            rom[i] = mat8(longint'($urandom_range(0, 262144)) - ONE, longint'($urandom_range(0, 262144)) - ONE,
                          longint'($urandom_range(0, 262144)) - ONE, longint'($urandom_range(0, 262144)) - ONE,
                          longint'($urandom_range(0, 262144)) - ONE, longint'($urandom_range(0, 262144)) - ONE,
                          longint'($urandom_range(0, 262144)) - ONE, longint'($urandom_range(0, 262144)) - ONE);
        end
        model_clear();
        #1;
        check("rst_available", DW'(available),    DW'(1'b1));
        check("rst_valid",     DW'(result_valid), DW'(1'b0));
        check("rst_addr",      DW'(gate_addr),    DW'(0));
        check("rst_result",    result_data,       DW'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Non-first gate straight after reset multiplies the zero cache.
        send("zero_cache", 1, 0, 1'b0, 1'b0);

        send("ident", 0, 0, 1'b1, 1'b0);
        check("ident_const", result_data, mat8(ONE, 0, 0, 0, 0, 0, ONE, 0));

        send("xx_a", 1, 1, 1'b1, 1'b0);
        send("xx_b", 1, 0, 1'b0, 1'b0);
        check("xx_const", result_data, mat8(ONE, 0, 0, 0, 0, 0, ONE, 0));

        send("hh_a", 2, 1, 1'b1, 1'b0);
        send("hh_b", 2, 0, 1'b0, 1'b0);
        check("hh_const", result_data, mat8(ONE, 0, 0, 0, 0, 0, ONE, 0));

        send("zs_a", 3, 1, 1'b1, 1'b0);
        send("zs_b", 4, 0, 1'b0, 1'b0);
        check("zs_const", result_data, mat8(ONE, 0, 0, 0, 0, 0, 0, -ONE));

        // Ready held through the busy window; index 2 never finishes a sequence.
        send("hold_a", 5, 2, 1'b1, 1'b1);
        send("hold_b", 6, 2, 1'b0, 1'b1);

        // Abort at MAC step 3 with an asynchronous reset.
        send("abort_pre", 2, 1, 1'b1, 1'b0);
        seq_gate = 5'd1; seq_index = '0; first = 1'b0; ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("abort_busy", DW'(available), DW'(1'b0));
        reset = 1'b1;
        #1;
        check("abort_result",    result_data,       DW'(0));
        check("abort_available", DW'(available),    DW'(1'b1));
        check("abort_addr",      DW'(gate_addr),    DW'(0));
        check("abort_valid",     DW'(result_valid), DW'(1'b0));
        repeat (2) @(negedge clk);
        check("abort_valid_hold", DW'(result_valid), DW'(1'b0));
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        send("abort_fresh", 4, 0, 1'b1, 1'b0);

        // Random sequences, occasionally restarting with a first gate mid-way.
        for (int s = 0; s < 6; s++) begin
            len = int'($urandom_range(1, 4));
            for (int i = len - 1; i >= 0; i--) begin
                g = int'($urandom_range(0, 31));
                f = (i == len - 1) || ($urandom_range(0, 7) == 0);
                send($sformatf("rnd%0d_%0d", s, i), g, i, f, 1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
